// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised progressive raster timing generator.
//
// Ports:
//   clk_i           single system clock
//   rst_ni          synchronous active-low reset
//   ce_i            pixel advance enable
//   run_en_i        1 = run, 0 = stop at the end of the current frame
//   px_o, py_o      current column / line
//   hsync_o/vsync_o sync outputs with configurable active level
//   de_o            display enable (visible area while active)
//   hblank_o        px >= H_VISIBLE (forced high when idle)
//   vblank_o        py >= V_VISIBLE (forced high when idle)
//   line_start_o    one-clk strobe on entering px == 0
//   frame_start_o   one-clk strobe on entering (0,0) while running
//   frame_end_o     one-clk strobe on entering the last position of a frame
//   frame_count_o   completed frames, wraps
//   active_o        high while running or draining
//
// All outputs come straight from registers loaded from the same next position,
// so every output in a given cycle describes the same pixel.
module video_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned COORD_W   = 11,
    parameter int unsigned FCNT_W    = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               ce_i,
    input  logic               run_en_i,
    output logic [COORD_W-1:0] px_o,
    output logic [COORD_W-1:0] py_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               de_o,
    output logic               hblank_o,
    output logic               vblank_o,
    output logic               line_start_o,
    output logic               frame_start_o,
    output logic               frame_end_o,
    output logic [FCNT_W-1:0]  frame_count_o,
    output logic               active_o
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (H_VISIBLE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
        V_VISIBLE == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0 ||
        COORD_W == 0 || FCNT_W == 0) begin : g_bad_zero
        $error("video_timing_gen: timing parameters and widths must be non-zero");
    end
    if (((H_TOTAL - 1) >> COORD_W) != 0 || ((V_TOTAL - 1) >> COORD_W) != 0) begin : g_bad_width
        $error("video_timing_gen: COORD_W too narrow for H_TOTAL/V_TOTAL");
    end

    localparam logic [COORD_W-1:0] HVis    = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] HSyncLo = COORD_W'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_W-1:0] HSyncHi = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] HLast   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] VVis    = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] VSyncLo = COORD_W'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_W-1:0] VSyncHi = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [COORD_W-1:0] VLast   = COORD_W'(V_TOTAL - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e              state_q, state_d;
    logic [COORD_W-1:0]  px_q, px_d, py_q, py_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic                hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic                hblank_q, hblank_d, vblank_q, vblank_d;
    logic                line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic                frame_end_q, frame_end_d;
    logic                adv, last_adv, enter;

    assign adv      = (state_q != StIdle) && ce_i;
    assign last_adv = adv && (px_q == HLast) && (py_q == VLast);

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= StIdle;
        else         state_q <= state_d;
    end

    // Next-state logic; a re-request while draining wins over the frame-end stop.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (run_en_i) state_d = StRun;
            StRun:   if (!run_en_i) state_d = StDrain;
            StDrain: begin
                if (run_en_i)      state_d = StRun;
                else if (last_adv) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Next position and next output values, all derived from the same (px_d, py_d).
    always_comb begin
        px_d = px_q;
        py_d = py_q;
        if (state_d == StIdle) begin
            px_d = '0;
            py_d = '0;
        end else if (adv) begin
            if (px_q == HLast) begin
                px_d = '0;
                py_d = (py_q == VLast) ? '0 : py_q + COORD_W'(1);
            end else begin
                px_d = px_q + COORD_W'(1);
            end
        end

        // Leaving IDLE counts as entering (0,0) so the first pixel gets its strobes.
        enter  = adv || (state_q == StIdle && state_d == StRun);
        fcnt_d = last_adv ? fcnt_q + FCNT_W'(1) : fcnt_q;

        hblank_d      = 1'b1;
        vblank_d      = 1'b1;
        de_d          = 1'b0;
        hsync_d       = ~HSYNC_POL;
        vsync_d       = ~VSYNC_POL;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        if (state_d != StIdle) begin
            hblank_d      = (px_d >= HVis);
            vblank_d      = (py_d >= VVis);
            de_d          = ~hblank_d & ~vblank_d;
            hsync_d       = (px_d >= HSyncLo && px_d < HSyncHi) ? HSYNC_POL : ~HSYNC_POL;
            vsync_d       = (py_d >= VSyncLo && py_d < VSyncHi) ? VSYNC_POL : ~VSYNC_POL;
            line_start_d  = enter && (px_d == '0);
            frame_start_d = enter && (px_d == '0) && (py_d == '0);
            frame_end_d   = enter && (px_d == HLast) && (py_d == VLast);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            px_q          <= '0;
            py_q          <= '0;
            fcnt_q        <= '0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            de_q          <= 1'b0;
            hblank_q      <= 1'b1;
            vblank_q      <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
        end else begin
            px_q          <= px_d;
            py_q          <= py_d;
            fcnt_q        <= fcnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
        end
    end

    assign px_o          = px_q;
    assign py_o          = py_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign de_o          = de_q;
    assign hblank_o      = hblank_q;
    assign vblank_o      = vblank_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;
    assign frame_end_o   = frame_end_q;
    assign frame_count_o = fcnt_q;
    assign active_o      = (state_q != StIdle);

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for the display pipeline. It produces pixel coordinates, sync, blanking and frame/line strobes for any progressive video mode, and replaces the fixed 640x480 timing block. Compared with that block it adds configurable sync polarity, a pixel clock-enable for divided pixel rates, a run/stop state machine that only stops at frame boundaries, and a frame counter. All outputs are registered and mutually aligned.

## Interface
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BACK, 48, horizontal back porch
- V_VISIBLE, 480, active lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BACK, 33, vertical back porch
- HSYNC_POL, 0, active level of hsync
- VSYNC_POL, 0, active level of vsync
- COORD_W, 11, width of px/py
- FCNT_W, 16, width of frame_count

Ports:
- clk  in  1  system clock; the design has one clock only
- rst_n  in  1  reset; synchronous, active-low
- ce  in  1  pixel advance enable, qualified on clk
- run_en  in  1  request to run (1) or stop at end of frame (0)
- px  out  COORD_W  current column, 0..H_TOTAL-1
- py  out  COORD_W  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity HSYNC_POL
- vsync  out  1  vertical sync, polarity VSYNC_POL
- de  out  1  display enable, high in the visible area
- hblank  out  1  high when px >= H_VISIBLE
- vblank  out  1  high when py >= V_VISIBLE
- line_start  out  1  one-clk strobe on entering px==0
- frame_start  out  1  one-clk strobe on entering (0,0) while running
- frame_end  out  1  one-clk strobe on entering (H_TOTAL-1, V_TOTAL-1)
- frame_count  out  FCNT_W  completed frames, wraps modulo 2^FCNT_W
- active  out  1  high in RUN or DRAIN

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK. V_TOTAL is the vertical sum of the same four terms.
- Elaboration fails if H_TOTAL-1 or V_TOTAL-1 does not fit in COORD_W, or if any parameter is 0.
- hsync is active when H_VISIBLE+H_FRONT <= px < H_VISIBLE+H_FRONT+H_SYNC. It is ~HSYNC_POL otherwise. vsync follows the same rule on py.
- de = ~hblank & ~vblank, evaluated in RUN or DRAIN only.
- States:
  - IDLE: px=py=0, de=0, hblank=vblank=1, syncs inactive, strobes 0, active=0.
  - RUN: position advances on every clk with ce=1. px wraps at H_TOTAL-1 and increments py. py wraps at V_TOTAL-1.
  - DRAIN: advances exactly like RUN.
- Transitions:
  - IDLE→RUN when run_en=1, evaluated every clk and independent of ce.
  - RUN→DRAIN when run_en=0.
  - DRAIN→RUN when run_en=1. There is no positional discontinuity.
  - DRAIN→IDLE on the ce-qualified advance out of (H_TOTAL-1, V_TOTAL-1).
- frame_count increments by 1 on every advance out of (H_TOTAL-1, V_TOTAL-1), in both RUN and DRAIN.
- Sync, blank and de outputs are computed from the next position and registered together with px/py. In any clk cycle all outputs describe the same position.

## Timing
- Reset (rst_n=0 at posedge): state IDLE, frame_count=0, all outputs at their IDLE values. Reset overrides ce and run_en. Reset in mid-frame returns to IDLE on the next edge.
- Start: run_en sampled high in IDLE. In the next cycle px=py=0, active=1, de=1, line_start=1 and frame_start=1. The first advance needs ce.
- ce=0: every output holds except strobes, which drop to 0 after one clk. Each strobe is high exactly one clk per qualifying entry, even when ce is high for only 1 cycle in N.
- Wrap to (0,0) while in RUN: frame_start=1, line_start=1, frame_count+1, all in the same cycle.
- DRAIN exit: the cycle after the final advance shows the IDLE values. frame_count is updated and frame_start=0.
- run_en toggling within a frame has no effect on position.

## Test plan
- Small mode (H 8/2/2/2, V 4/1/1/1, ce=1, run_en=1) → px cycles 0..13; hsync low only at px 10..11; vsync low only at py 5; frame_start every 98 clks; de high on 32 clks per frame.
- Default 640x480, HSYNC_POL=1 → hsync high at px 656..751; 800x525 = 420000 clks between frame_start pulses; frame_count=3 after 3 frames.
- ce=1 one cycle in 4, small mode → one frame spans 392 clks; each of line_start/frame_start/frame_end is 1 clk wide; outputs hold between advances.
- run_en dropped at (3,2) → frame completes to (13,6); next cycle IDLE, px=py=0, active=0, frame_count+1. Re-asserting in DRAIN keeps running with no gap.
- rst_n=0 at (5,3) mid-frame → next cycle IDLE values, frame_count=0. Restart produces frame_start at (0,0).
- frame_count with FCNT_W=2 → after 4 frames it reads 0.
